// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared types and constants for the systolic array sequencer.
// MAC widths describe the array datapath; the sequencer itself moves no data.
package systolic_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

    localparam int MAC_ACT_W  = 8;
    localparam int MAC_W_W    = 8;
    localparam int MAC_PSUM_W = 24;

    // Cycles for the last activation to clear the skew and reach column N-1.
    function automatic int drain_len(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/seq_delay_line.sv
// 1-bit shift register exposing every tap; taps[k] is din delayed k+1 cycles.
// Latency 1..DEPTH cycles, no backpressure, async active-low clear.
module seq_delay_line #(
    parameter int DEPTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    output logic [DEPTH-1:0] taps
);

    generate
        if (DEPTH == 1) begin : g_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) taps <= '0;
                else        taps <= din;
            end
        end else begin : g_many
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) taps <= '0;
                else        taps <= {taps[DEPTH-2:0], din};
            end
        end
    endgenerate

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for an N x N weight-stationary systolic array: weight load, activation stream, drain.
// Outputs decode from registered state; start is only honoured in IDLE, no queueing.
module systolic_seq_ctrl
    import systolic_seq_ctrl_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_rows,
    output logic                 busy,
    output logic                 done,
    output logic                 w_ld_en,
    output logic [$clog2(N)-1:0] w_ld_row,
    output logic                 act_rd_en,
    output logic [CNT_W-1:0]     act_rd_addr,
    output logic [N-1:0]         act_row_valid,
    output logic [N-1:0]         out_col_valid
);

    localparam int DLEN = drain_len(N);
    localparam int RW   = $clog2(N);
    localparam int CW   = (CNT_W >= $clog2(DLEN + 1)) ? CNT_W : $clog2(DLEN + 1);

    seq_state_t       state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [CNT_W-1:0] m_q, m_nxt;
    logic [CW-1:0]    m_last;
    logic [DLEN-1:0]  taps;

    assign m_last = CW'(m_q) - CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            m_q   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            m_q   <= m_nxt;
        end
    end

    // One shared phase counter: every phase restarts it at zero.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        m_nxt     = m_q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD_W;
                    cnt_nxt   = '0;
                    m_nxt     = num_rows;
                end
            end
            LOAD_W: begin
                if (cnt == CW'(N - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = (m_q == '0) ? DONE : STREAM;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            STREAM: begin
                if (cnt == m_last) begin
                    cnt_nxt   = '0;
                    state_nxt = DRAIN;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DRAIN: begin
                if (cnt == CW'(DLEN - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign w_ld_en     = (state == LOAD_W);
    assign w_ld_row    = w_ld_en ? cnt[RW-1:0] : '0;
    assign act_rd_en   = (state == STREAM);
    assign act_rd_addr = act_rd_en ? cnt[CNT_W-1:0] : '0;

    // Skew taps depend only on act_rd_en history, so strobes survive state changes.
    seq_delay_line #(.DEPTH(DLEN)) u_skew (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (act_rd_en),
        .taps  (taps)
    );

    assign act_row_valid = {taps[N-2:0], act_rd_en};
    assign out_col_valid = taps[DLEN-1:N-1];

endmodule
